// File: rtl/univ_shift_reg.sv
// Universal shift register: hold / shift left / shift right / parallel load,
// plus a counted burst engine that shifts len bits and then pulses done.
module univ_shift_reg #(
    parameter int                 WIDTH   = 8,
    parameter int                 CNT_W   = 4,
    parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             sin,
    input  logic [WIDTH-1:0] pdin,
    input  logic             start,
    input  logic             dir,
    input  logic [CNT_W-1:0] len,
    output logic [WIDTH-1:0] q,
    output logic             sout_msb,
    output logic             sout_lsb,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHL  = 2'b01,
        MODE_SHR  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    state_e             state, state_n;
    logic [WIDTH-1:0]   q_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               dir_r, dir_n;
    logic [WIDTH-1:0]   shl_val, shr_val;

    // Serial taps come straight from the register, no extra flops.
    assign sout_msb = q[WIDTH-1];
    assign sout_lsb = q[0];

    assign shl_val = {q[WIDTH-2:0], sin};
    assign shr_val = {sin, q[WIDTH-1:1]};

    // Next-state, next-data and next-count selection for the burst FSM and direct modes.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned
        // (which would infer a latch); combinational logic uses blocking '='.
        state_n = state;
        q_n     = q;
        cnt_n   = cnt;
        dir_n   = dir_r;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    // Burst request wins over the direct mode; q is untouched this edge.
                    if (len != '0) begin
                        state_n = ST_SHIFT;
                        cnt_n   = len;
                        dir_n   = dir;
                    end else begin
                        state_n = ST_DONE;
                    end
                end else if (en) begin
                    case (mode_e'(mode))
                        MODE_SHL:  q_n = shl_val;
                        MODE_SHR:  q_n = shr_val;
                        MODE_LOAD: q_n = pdin;
                        default:   q_n = q;
                    endcase
                end
            end
            ST_SHIFT: begin
                // en=0 stalls the burst completely; mode/start/dir/len are ignored here.
                if (en) begin
                    q_n   = dir_r ? shr_val : shl_val;
                    cnt_n = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state_n = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State, data and status registers; busy/done are registered decodes of the next state.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking '<=' so all flops update from
        // pre-edge values; the reset is synchronous and sampled on the clock edge.
        if (!rst) begin
            state <= ST_IDLE;
            q     <= RST_VAL;
            cnt   <= '0;
            dir_r <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            q     <= q_n;
            cnt   <= cnt_n;
            dir_r <= dir_n;
            busy  <= (state_n == ST_SHIFT);
            done  <= (state_n == ST_DONE);
        end
    end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed self-checking bench for univ_shift_reg (default WIDTH=8, CNT_W=4, RST_VAL=0).
module tb_univ_shift_reg;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic       sin;
    logic [7:0] pdin;
    logic       start;
    logic       dir;
    logic [3:0] len;
    logic [7:0] q;
    logic       sout_msb;
    logic       sout_lsb;
    logic       busy;
    logic       done;

    int compared   = 0;
    int mismatched = 0;

    univ_shift_reg dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode     (mode),
        .sin      (sin),
        .pdin     (pdin),
        .start    (start),
        .dir      (dir),
        .len      (len),
        .q        (q),
        .sout_msb (sout_msb),
        .sout_lsb (sout_lsb),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle outputs away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] v);
        mode = 2'b11; pdin = v; start = 1'b0; en = 1'b1;
        step();
        mode = 2'b00;
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b1; mode = 2'b11; pdin = 8'hA5; start = 1'b1; len = 4'd0;
        step();
        compared++; if (q !== 8'h00) begin mismatched++; $display("FAIL reset_q got %h exp %h", q, 8'h00); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy got %b exp 0", busy); end
        compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL reset_done got %b exp 0", done); end
        rst = 1'b1; start = 1'b0;
        step();
        compared++; if (q !== 8'hA5) begin mismatched++; $display("FAIL reset_release_load got %h exp %h", q, 8'hA5); end
    endtask

    task automatic test_direct_modes();
        logic [7:0] exp_q [4];
        logic       exp_msb [4];
        exp_q   = '{8'h4B, 8'h97, 8'h2F, 8'h5F};
        exp_msb = '{1'b1, 1'b0, 1'b1, 1'b0};
        load(8'hA5);
        mode = 2'b01; sin = 1'b1;
        for (int i = 0; i < 4; i++) begin
            compared++; if (sout_msb !== exp_msb[i]) begin mismatched++; $display("FAIL shl_msb[%0d] got %b exp %b", i, sout_msb, exp_msb[i]); end
            step();
            compared++; if (q !== exp_q[i]) begin mismatched++; $display("FAIL shl_q[%0d] got %h exp %h", i, q, exp_q[i]); end
        end
        load(8'hA5);
        mode = 2'b10; sin = 1'b0;
        step();
        compared++; if (q !== 8'h52) begin mismatched++; $display("FAIL shr_q1 got %h exp %h", q, 8'h52); end
        step();
        compared++; if (q !== 8'h29) begin mismatched++; $display("FAIL shr_q2 got %h exp %h", q, 8'h29); end
        mode = 2'b00; sin = 1'b1;
        for (int i = 0; i < 3; i++) step();
        compared++; if (q !== 8'h29) begin mismatched++; $display("FAIL hold_q got %h exp %h", q, 8'h29); end
        compared++; if (sout_lsb !== 1'b1) begin mismatched++; $display("FAIL hold_lsb got %b exp 1", sout_lsb); end
    endtask

    task automatic test_burst();
        logic [7:0] exp_q [3];
        exp_q = '{8'h02, 8'h04, 8'h08};
        load(8'h81);
        start = 1'b1; dir = 1'b0; len = 4'd3; sin = 1'b0;
        step();
        start = 1'b0;
        compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL bl_busy0 got %b exp 1", busy); end
        compared++; if (q !== 8'h81) begin mismatched++; $display("FAIL bl_q0 got %h exp %h", q, 8'h81); end
        for (int i = 0; i < 3; i++) begin
            step();
            compared++; if (q !== exp_q[i]) begin mismatched++; $display("FAIL bl_q[%0d] got %h exp %h", i, q, exp_q[i]); end
            compared++; if (busy !== (i < 2)) begin mismatched++; $display("FAIL bl_busy[%0d] got %b exp %b", i, busy, (i < 2)); end
            compared++; if (done !== (i == 2)) begin mismatched++; $display("FAIL bl_done[%0d] got %b exp %b", i, done, (i == 2)); end
        end
        step();
        compared++; if ({busy, done} !== 2'b00) begin mismatched++; $display("FAIL bl_idle got %b exp 00", {busy, done}); end
        load(8'h81);
        start = 1'b1; dir = 1'b1; len = 4'd2; sin = 1'b1;
        step();
        start = 1'b0;
        step();
        compared++; if (q !== 8'hC0) begin mismatched++; $display("FAIL br_q1 got %h exp %h", q, 8'hC0); end
        step();
        compared++; if (q !== 8'hE0) begin mismatched++; $display("FAIL br_q2 got %h exp %h", q, 8'hE0); end
        compared++; if (done !== 1'b1) begin mismatched++; $display("FAIL br_done got %b exp 1", done); end
        step();
    endtask

    task automatic test_stall();
        load(8'h3C);
        start = 1'b1; dir = 1'b0; len = 4'd4; sin = 1'b0;
        step();
        // Junk on mode/start/dir/len during the burst must be ignored.
        mode = 2'b11; pdin = 8'hFF; start = 1'b1; len = 4'd1; dir = 1'b1;
        step();
        compared++; if (q !== 8'h78) begin mismatched++; $display("FAIL st_q1 got %h exp %h", q, 8'h78); end
        en = 1'b0;
        step(); step();
        compared++; if (q !== 8'h78) begin mismatched++; $display("FAIL st_hold_q got %h exp %h", q, 8'h78); end
        compared++; if ({busy, done} !== 2'b10) begin mismatched++; $display("FAIL st_hold_bd got %b exp 10", {busy, done}); end
        en = 1'b1;
        step();
        compared++; if (q !== 8'hF0) begin mismatched++; $display("FAIL st_q2 got %h exp %h", q, 8'hF0); end
        compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL st_early_done got %b exp 0", done); end
        step();
        compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL st_early_done2 got %b exp 0", done); end
        step();
        compared++; if (q !== 8'hC0) begin mismatched++; $display("FAIL st_final_q got %h exp %h", q, 8'hC0); end
        compared++; if ({busy, done} !== 2'b01) begin mismatched++; $display("FAIL st_done got %b exp 01", {busy, done}); end
        // start and mode=11 still asserted while in DONE: both ignored.
        step();
        compared++; if (q !== 8'hC0) begin mismatched++; $display("FAIL st_done_ignore_q got %h exp %h", q, 8'hC0); end
        compared++; if ({busy, done} !== 2'b00) begin mismatched++; $display("FAIL st_done_ignore_bd got %b exp 00", {busy, done}); end
        start = 1'b0; mode = 2'b00; dir = 1'b0;
    endtask

    task automatic test_zero_and_overflow();
        load(8'h5A);
        start = 1'b1; len = 4'd0; mode = 2'b01; sin = 1'b1;
        step();
        start = 1'b0; mode = 2'b00;
        compared++; if ({busy, done} !== 2'b01) begin mismatched++; $display("FAIL zl_bd got %b exp 01", {busy, done}); end
        compared++; if (q !== 8'h5A) begin mismatched++; $display("FAIL zl_q got %h exp %h", q, 8'h5A); end
        step();
        compared++; if ({busy, done} !== 2'b00) begin mismatched++; $display("FAIL zl_after got %b exp 00", {busy, done}); end
        load(8'h00);
        start = 1'b1; dir = 1'b0; len = 4'd10; sin = 1'b1;
        step();
        start = 1'b0;
        for (int i = 1; i <= 9; i++) step();
        compared++; if (q !== 8'hFF) begin mismatched++; $display("FAIL ov_q9 got %h exp %h", q, 8'hFF); end
        compared++; if ({busy, done} !== 2'b10) begin mismatched++; $display("FAIL ov_bd9 got %b exp 10", {busy, done}); end
        step();
        compared++; if ({busy, done} !== 2'b01) begin mismatched++; $display("FAIL ov_bd10 got %b exp 01", {busy, done}); end
        compared++; if (q !== 8'hFF) begin mismatched++; $display("FAIL ov_q10 got %h exp %h", q, 8'hFF); end
        step();
    endtask

    task automatic test_reset_mid_burst();
        load(8'h0F);
        start = 1'b1; dir = 1'b1; len = 4'd5; sin = 1'b1;
        step();
        start = 1'b0;
        step();
        compared++; if (q !== 8'h87) begin mismatched++; $display("FAIL rb_q1 got %h exp %h", q, 8'h87); end
        rst = 1'b0;
        step();
        rst = 1'b1;
        compared++; if (q !== 8'h00) begin mismatched++; $display("FAIL rb_q got %h exp %h", q, 8'h00); end
        compared++; if ({busy, done} !== 2'b00) begin mismatched++; $display("FAIL rb_bd got %b exp 00", {busy, done}); end
        for (int i = 0; i < 5; i++) begin
            step();
            compared++; if ({busy, done} !== 2'b00) begin mismatched++; $display("FAIL rb_no_done[%0d] got %b exp 00", i, {busy, done}); end
        end
        compared++; if (q !== 8'h00) begin mismatched++; $display("FAIL rb_q_hold got %h exp %h", q, 8'h00); end
        start = 1'b1; dir = 1'b0; len = 4'd2; sin = 1'b1;
        step();
        start = 1'b0;
        step();
        compared++; if (q !== 8'h01) begin mismatched++; $display("FAIL rb_new_q1 got %h exp %h", q, 8'h01); end
        step();
        compared++; if (q !== 8'h03) begin mismatched++; $display("FAIL rb_new_q2 got %h exp %h", q, 8'h03); end
        compared++; if ({busy, done} !== 2'b01) begin mismatched++; $display("FAIL rb_new_done got %b exp 01", {busy, done}); end
        step();
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; mode = 2'b00; sin = 1'b0; pdin = 8'h00;
        start = 1'b0; dir = 1'b0; len = 4'd0;
        #2;
        test_reset();
        test_direct_modes();
        test_burst();
        test_stall();
        test_zero_and_overflow();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
Parametrised universal shift register that succeeds the fixed single-direction SISO register. It supports hold, shift-left, shift-right and parallel-load modes, with serial taps at both ends. It also has a counted burst engine that shifts a programmed number of bits and then pulses done. It is the common serialiser/deserialiser primitive for the team's serial peripherals.

Parameters:
WIDTH, 8, register width in bits (minimum 2)
CNT_W, 4, width of the burst length input; burst length range is 0..2^CNT_W-1
RST_VAL, 0, value loaded into q on reset (WIDTH bits)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-low reset
en  input  1  clock enable for all shift and load actions; when 0, q and the burst count hold
mode  input  2  direct-mode operation: 00 hold, 01 shift left, 10 shift right, 11 parallel load
sin  input  1  serial data in; enters at LSB on a left shift and at MSB on a right shift
pdin  input  WIDTH  parallel load data
start  input  1  burst request, sampled only in IDLE
dir  input  1  burst direction, latched at start: 0 left, 1 right
len  input  CNT_W  burst shift count, latched at start
q  output  WIDTH  register contents, registered
sout_msb  output  1  equals q[WIDTH-1]
sout_lsb  output  1  equals q[0]
busy  output  1  registered; high while in SHIFT
done  output  1  registered; single-cycle pulse at burst completion

Behaviour:
- Reset: on a posedge with rst=0, q=RST_VAL, state=IDLE, busy=0, done=0 and count=0. Reset overrides every other input, including en. Reset during a burst aborts it and no done pulse is produced.
- Shift-left rule: q <= {q[WIDTH-2:0], sin}.
- Shift-right rule: q <= {sin, q[WIDTH-1:1]}.
- Serial outputs: sout_msb and sout_lsb are combinational from q, so there are no extra flops.
- State machine, IDLE:
  - If start=1 and len!=0 at the posedge: latch dir, set count=len, go to SHIFT. q is not modified on this edge.
  - If start=1 and len==0: go to DONE. q is unchanged.
  - Otherwise, if en=1, apply mode (01 shift left, 10 shift right, 11 q<=pdin, 00 hold).
  - Priority: start takes priority over mode in the same cycle.
- State machine, SHIFT:
  - Each posedge with en=1 shifts one bit in the latched direction and decrements count.
  - On the edge where count goes 1->0, go to DONE.
  - en=0 stalls: q, count and state all hold.
  - mode, start, dir and len are ignored while in SHIFT.
- State machine, DONE: done=1 for exactly one cycle, then IDLE unconditionally. mode and start are ignored in DONE.
- Burst timing: with en held at 1, a burst issued at edge 0 shifts on edges 1..len. busy is high from after edge 0 through edge len. done is high between edges len and len+1. busy and done are never high together.
- len > WIDTH is legal. The register is flushed completely and then filled with sin values.
- sin is sampled on every shifting edge, so a bench can deserialise by driving sin each cycle.

Test Plan:
1. Reset priority: rst=0 held with en=1, mode=11, pdin=8'hA5, start=1 -> after the posedge q=8'h00, busy=0, done=0. Release rst -> next edge loads 8'hA5 (mode 11 applies; start with len=0 is covered separately).
2. Direct modes: load 8'hA5, then mode=01, sin=1 for 4 edges -> q=8'h5F, sout_msb before each shift 1,0,1,0. Reload 8'hA5, mode=10, sin=0 for 2 edges -> q=8'h29. mode=00 for 3 edges -> q holds 8'h29.
3. Burst left: load 8'h81, then start=1, dir=0, len=3, sin=0 -> busy high 3 cycles, q=8'h08 after edge 3, done high for one cycle after that, then IDLE. Burst right with len=2 from 8'h81 and sin=1 -> q=8'hE0.
4. Enable stall: burst with len=4, en=0 for 2 cycles after the first shift -> done delayed by exactly 2 cycles, final q matches the unstalled result. mode=11 and start pulses driven during busy have no effect.
5. Zero length and overflow: start with len=0 -> done pulses on the next cycle, busy stays 0, q unchanged. start with len=10 (WIDTH=8), sin=1 from 8'h00 -> q=8'hFF, done after the 10th shift.
6. Reset mid-burst: rst=0 on the 2nd shift of a len=5 burst -> q=RST_VAL, busy=0, no done pulse. A new start after rst=1 operates normally.
